bcd_entry_to_bin: RTL and testbench

- Time-setting input path for the clock: takes two BCD digits, tens first, from the keypad/button digit source over a valid/ready handshake.
- Range-checks the pair against a per-field maximum and produces the binary value (0..59) for the minute, second or hour register.
- Inverse of the display-side binary-to-BCD path; one instance per settable field (seconds, minutes, hours).

---
 rtl/clock_pkg.sv | 10 +
 rtl/bcd_entry_to_bin_pair.sv | 8 +
 rtl/bcd_entry_to_bin.sv | 106 ++++++++++
 tb/tb_bcd_entry_to_bin.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/clock_pkg.sv
// clock_pkg: shared entry-phase encoding, error codes and per-field maxima
package clock_pkg;
  typedef enum logic [1:0] {TENS = 2'd0, ONES = 2'd1, CONV = 2'd2, HOLD = 2'd3} phase_t;
  localparam logic [1:0] ERR_BCD     = 2'd1;
  localparam logic [1:0] ERR_RANGE   = 2'd2;
  localparam logic [1:0] ERR_TIMEOUT = 2'd3;
  localparam int SEC_MAX = 59;
  localparam int MIN_MAX = 59;
  localparam int HR_MAX  = 23;
endpackage

// File: rtl/bcd_entry_to_bin_pair.sv
// bcd_pair_to_bin: combinational tens*10+ones as (tens<<3)+(tens<<1)+ones, 7-bit result
module bcd_pair_to_bin (
  input  logic [3:0] i_tens,
  input  logic [3:0] i_ones,
  output logic [6:0] o_val
);
  assign o_val = {i_tens, 3'b000} + {2'b00, i_tens, 1'b0} + {3'b000, i_ones};
endmodule

// File: rtl/bcd_entry_to_bin.sv
// bcd_entry_to_bin: two-digit BCD entry (tens, ones) over valid/ready, range-checked to binary 0..MAX_VAL
module bcd_entry_to_bin
  import clock_pkg::*;
#(
  parameter int MAX_VAL        = 59,
  parameter int TIMEOUT_CYCLES = 50000000,
  parameter int TMR_W          = $clog2(TIMEOUT_CYCLES)
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       digit_valid,
  input  logic [3:0] digit,
  output logic       digit_ready,
  input  logic       cancel,
  output logic       bin_valid,
  output logic [5:0] bin,
  input  logic       bin_ready,
  output logic [1:0] entry_phase,
  output logic       err,
  output logic [1:0] err_code
);
  localparam logic [TMR_W-1:0] TMO_LAST = TMR_W'(TIMEOUT_CYCLES - 1);
  phase_t           r_state, w_next;
  logic [3:0]       r_tens, r_ones, w_t, w_o;
  logic [5:0]       r_bin;
  logic             r_bin_valid, r_err, w_err, w_ld_t, w_ld_o;
  logic [1:0]       r_err_code, w_code;
  logic [TMR_W-1:0] r_tmr;
  logic [6:0]       w_val;
  logic             w_acc, w_bad, w_over, w_tmo;
  assign w_t = (r_state == TENS) ? digit : r_tens;
  assign w_o = (r_state == TENS) ? 4'd0 : (r_state == ONES) ? digit : r_ones;
  bcd_pair_to_bin u_pair (.i_tens(w_t), .i_ones(w_o), .o_val(w_val));
  assign digit_ready = (r_state == TENS) || (r_state == ONES);
  assign w_acc       = digit_valid && digit_ready;
  assign w_bad       = digit > 4'd9;
  assign w_over      = w_val > 7'(MAX_VAL);
  assign w_tmo       = r_tmr == TMO_LAST;
  always_comb begin
    w_next = r_state;
    w_err  = 1'b0;
    w_code = r_err_code;
    w_ld_t = 1'b0;
    w_ld_o = 1'b0;
    if (cancel) w_next = TENS;
    else case (r_state)
      TENS: if (w_acc) begin
        if (w_bad) begin
          w_err  = 1'b1;
          w_code = ERR_BCD;
        end else if (w_over) begin
          w_err  = 1'b1;
          w_code = ERR_RANGE;
        end else begin
          w_ld_t = 1'b1;
          w_next = ONES;
        end
      end
      ONES: if (w_acc) begin
        if (w_bad) begin
          w_err  = 1'b1;
          w_code = ERR_BCD;
        end else if (w_over) begin
          w_err  = 1'b1;
          w_code = ERR_RANGE;
          w_next = TENS;
        end else begin
          w_ld_o = 1'b1;
          w_next = CONV;
        end
      end else if (w_tmo) begin
        w_err  = 1'b1;
        w_code = ERR_TIMEOUT;
        w_next = TENS;
      end
      CONV: w_next = HOLD;
      default: w_next = bin_ready ? TENS : HOLD;
    endcase
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= TENS;
      r_tens      <= '0;
      r_ones      <= '0;
      r_bin       <= '0;
      r_bin_valid <= 1'b0;
      r_err       <= 1'b0;
      r_err_code  <= '0;
      r_tmr       <= '0;
    end else begin
      r_state     <= w_next;
      r_err       <= w_err;
      r_err_code  <= w_code;
      r_tens      <= w_ld_t ? digit : r_tens;
      r_ones      <= w_ld_o ? digit : r_ones;
      r_tmr       <= (r_state == ONES && !cancel) ? r_tmr + 1'b1 : '0;
      r_bin_valid <= cancel ? 1'b0 : (r_state == CONV) ? 1'b1 : (r_state == HOLD && bin_ready) ? 1'b0 : r_bin_valid;
      r_bin       <= (r_state == CONV && !cancel) ? w_val[5:0] : r_bin;
    end
  end
  assign bin_valid   = r_bin_valid;
  assign bin         = r_bin;
  assign entry_phase = r_state;
  assign err         = r_err;
  assign err_code    = r_err_code;
endmodule

// File: tb/tb_bcd_entry_to_bin.sv
// tb_bcd_entry_to_bin: directed stimulus into a 59-max and a 23-max instance, checked against a per-cycle model
module tb_bcd_entry_to_bin;
  localparam int TO = 8;
  logic       clk = 1'b0, rst = 1'b1;
  logic       digit_valid = 1'b0, cancel = 1'b0, bin_ready = 1'b1;
  logic [3:0] digit = 4'd0;
  logic       o_rdy[2], o_bv[2], o_err[2];
  logic [5:0] o_bin[2];
  logic [1:0] o_ph[2], o_code[2];
  int tests = 0, fails = 0;
  int mx[2] = '{59, 23};
  int ph[2], mt[2], mo[2], mn[2], mbin[2], mbv[2], merr[2], mcode[2];
  always #5 clk = ~clk;
  bcd_entry_to_bin #(.MAX_VAL(59), .TIMEOUT_CYCLES(TO)) u_a (
    .clk(clk), .rst(rst), .digit_valid(digit_valid), .digit(digit), .digit_ready(o_rdy[0]),
    .cancel(cancel), .bin_valid(o_bv[0]), .bin(o_bin[0]), .bin_ready(bin_ready),
    .entry_phase(o_ph[0]), .err(o_err[0]), .err_code(o_code[0]));
  bcd_entry_to_bin #(.MAX_VAL(23), .TIMEOUT_CYCLES(TO)) u_b (
    .clk(clk), .rst(rst), .digit_valid(digit_valid), .digit(digit), .digit_ready(o_rdy[1]),
    .cancel(cancel), .bin_valid(o_bv[1]), .bin(o_bin[1]), .bin_ready(bin_ready),
    .entry_phase(o_ph[1]), .err(o_err[1]), .err_code(o_code[1]));
  task automatic chk(input string nm, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask
  task automatic model_step(input int i, input bit v, input int d, input bit c, input bit br);
    merr[i] = 0;
    if (c) begin
      ph[i] = 0;
      mbv[i] = 0;
    end else if (ph[i] == 0) begin
      if (v) begin
        if (d > 9) begin merr[i] = 1; mcode[i] = 1; end
        else if (d * 10 > mx[i]) begin merr[i] = 1; mcode[i] = 2; end
        else begin mt[i] = d; mn[i] = 1; ph[i] = 1; end
      end
    end else if (ph[i] == 1) begin
      if (v) begin
        if (d > 9) begin merr[i] = 1; mcode[i] = 1; mn[i]++; end
        else if (mt[i] * 10 + d > mx[i]) begin merr[i] = 1; mcode[i] = 2; ph[i] = 0; end
        else begin mo[i] = d; ph[i] = 2; end
      end else if (mn[i] == TO) begin
        merr[i] = 1; mcode[i] = 3; ph[i] = 0;
      end else mn[i]++;
    end else if (ph[i] == 2) begin
      mbin[i] = mt[i] * 10 + mo[i];
      mbv[i] = 1;
      ph[i] = 3;
    end else if (br) begin
      mbv[i] = 0;
      ph[i] = 0;
    end
  endtask
  initial begin
    bit sv, sc, sbr, sr;
    int sd;
    forever begin
      @(posedge clk);
      sv = digit_valid; sd = int'(digit); sc = cancel; sbr = bin_ready; sr = rst;
      #1;
      for (int i = 0; i < 2; i++) begin
        if (sr) begin
          ph[i] = 0; mt[i] = 0; mo[i] = 0; mn[i] = 0; mbin[i] = 0; mbv[i] = 0; merr[i] = 0; mcode[i] = 0;
        end else model_step(i, sv, sd, sc, sbr);
        chk($sformatf("m%0d.phase", i), int'(o_ph[i]), ph[i]);
        chk($sformatf("m%0d.ready", i), int'(o_rdy[i]), int'(ph[i] <= 1));
        chk($sformatf("m%0d.bin_valid", i), int'(o_bv[i]), mbv[i]);
        chk($sformatf("m%0d.bin", i), int'(o_bin[i]), mbin[i]);
        chk($sformatf("m%0d.err", i), int'(o_err[i]), merr[i]);
        chk($sformatf("m%0d.err_code", i), int'(o_code[i]), mcode[i]);
      end
    end
  end
  task automatic cyc(input bit v, input int d, input bit c = 1'b0, input bit br = 1'b1);
    digit_valid = v;
    digit = 4'(d);
    cancel = c;
    bin_ready = br;
    @(negedge clk);
  endtask
  task automatic sync();
    cyc(0, 0, 1);
    cyc(0, 0);
  endtask
  initial begin
    @(negedge clk);
    chk("rst.ready", int'(o_rdy[0]), 1);
    chk("rst.phase", int'(o_ph[0]), 0);
    chk("rst.bin", int'(o_bin[0]), 0);
    chk("rst.code", int'(o_code[0]), 0);
    @(negedge clk);
    rst = 1'b0;
    cyc(1, 4);
    chk("a47.ph1", int'(o_ph[0]), 1);
    cyc(1, 7);
    chk("a47.conv", int'(o_ph[0]), 2);
    chk("a47.bv0", int'(o_bv[0]), 0);
    cyc(0, 0);
    chk("a47.bin", int'(o_bin[0]), 47);
    chk("a47.bv1", int'(o_bv[0]), 1);
    cyc(0, 0);
    chk("a47.bvdone", int'(o_bv[0]), 0);
    chk("a47.ph0", int'(o_ph[0]), 0);
    sync();
    cyc(1, 6);
    chk("a6.err", int'(o_err[0]), 1);
    chk("a6.code", int'(o_code[0]), 2);
    chk("a6.ph", int'(o_ph[0]), 0);
    cyc(1, 5);
    chk("a6.errpulse", int'(o_err[0]), 0);
    cyc(1, 9);
    cyc(0, 0);
    chk("a59.bin", int'(o_bin[0]), 59);
    cyc(0, 0);
    sync();
    cyc(1, 2);
    chk("b24.ph1", int'(o_ph[1]), 1);
    cyc(1, 4);
    chk("b24.code", int'(o_code[1]), 2);
    chk("b24.ph0", int'(o_ph[1]), 0);
    cyc(0, 0);
    cyc(0, 0);
    cyc(1, 2);
    cyc(1, 3);
    cyc(0, 0);
    chk("b23.bin", int'(o_bin[1]), 23);
    chk("b23.bv", int'(o_bv[1]), 1);
    cyc(0, 0);
    sync();
    cyc(1, 3);
    cyc(1, 10);
    chk("a3A.code", int'(o_code[0]), 1);
    chk("a3A.ph", int'(o_ph[0]), 1);
    cyc(1, 1);
    cyc(0, 0);
    chk("a31.bin", int'(o_bin[0]), 31);
    cyc(0, 0);
    sync();
    cyc(1, 1);
    for (int k = 0; k < TO - 1; k++) cyc(0, 0);
    chk("tmo.pre.ph", int'(o_ph[0]), 1);
    chk("tmo.pre.err", int'(o_err[0]), 0);
    cyc(0, 0);
    chk("tmo.err", int'(o_err[0]), 1);
    chk("tmo.code", int'(o_code[0]), 3);
    chk("tmo.ph", int'(o_ph[0]), 0);
    cyc(1, 1);
    for (int k = 0; k < TO - 1; k++) cyc(0, 0);
    cyc(1, 2);
    chk("tmo.win.ph", int'(o_ph[0]), 2);
    chk("tmo.win.err", int'(o_err[0]), 0);
    cyc(0, 0);
    chk("a12.bin", int'(o_bin[0]), 12);
    cyc(0, 0);
    sync();
    cyc(1, 0);
    cyc(1, 5);
    cyc(0, 0, 0, 0);
    for (int k = 0; k < 5; k++) begin
      cyc(k[0], 9, 0, 0);
      chk("hold.bin", int'(o_bin[0]), 5);
      chk("hold.bv", int'(o_bv[0]), 1);
      chk("hold.ready", int'(o_rdy[0]), 0);
    end
    cyc(0, 0);
    chk("hold.done.ph", int'(o_ph[0]), 0);
    chk("hold.done.bv", int'(o_bv[0]), 0);
    sync();
    cyc(1, 4);
    cyc(1, 5, 1);
    chk("cancel.ph", int'(o_ph[0]), 0);
    chk("cancel.err", int'(o_err[0]), 0);
    chk("cancel.bv", int'(o_bv[0]), 0);
    cyc(1, 2);
    cyc(1, 1);
    cyc(0, 0, 0, 0);
    cyc(0, 0, 0, 0);
    chk("pre_rst.bin", int'(o_bin[0]), 21);
    #2 rst = 1'b1;
    #1;
    chk("arst.bv", int'(o_bv[0]), 0);
    chk("arst.bin", int'(o_bin[0]), 0);
    chk("arst.ph", int'(o_ph[0]), 0);
    chk("arst.ready", int'(o_rdy[0]), 1);
    @(negedge clk);
    rst = 1'b0;
    cyc(0, 0);
    cyc(0, 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
